control_unit: RTL

CONTROL_UNIT -- requirements
Module: control_unit

---
 rtl/cpu_pkg.sv | 96 +++++++++
 rtl/reg_select.sv | 19 +
 rtl/control_unit.sv | 272 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/cpu_pkg.sv
// Shared definitions for the multi-cycle CPU control unit: FSM states,
// opcode and ALU control encodings, and opcode classification helpers.
package cpu_pkg;

  typedef enum logic [3:0] {
    S_RST  = 4'd0,
    S_T0   = 4'd1,
    S_T1   = 4'd2,
    S_T2   = 4'd3,
    S_T3   = 4'd4,
    S_T4   = 4'd5,
    S_T5   = 4'd6,
    S_T6   = 4'd7,
    S_T7   = 4'd8,
    S_HALT = 4'd9
  } state_t;

  localparam logic [4:0] OP_LD   = 5'b00000;
  localparam logic [4:0] OP_ST   = 5'b00010;
  localparam logic [4:0] OP_ADD  = 5'b00011;
  localparam logic [4:0] OP_SUB  = 5'b00100;
  localparam logic [4:0] OP_AND  = 5'b00101;
  localparam logic [4:0] OP_OR   = 5'b00110;
  localparam logic [4:0] OP_SHR  = 5'b00111;
  localparam logic [4:0] OP_SHL  = 5'b01000;
  localparam logic [4:0] OP_ROR  = 5'b01001;
  localparam logic [4:0] OP_ROL  = 5'b01010;
  localparam logic [4:0] OP_MUL  = 5'b01110;
  localparam logic [4:0] OP_DIV  = 5'b01111;
  localparam logic [4:0] OP_NEG  = 5'b10000;
  localparam logic [4:0] OP_NOT  = 5'b10001;
  localparam logic [4:0] OP_NOP  = 5'b11010;
  localparam logic [4:0] OP_HALT = 5'b11011;

  localparam logic [3:0] ALU_ADD = 4'd0;
  localparam logic [3:0] ALU_SUB = 4'd1;
  localparam logic [3:0] ALU_AND = 4'd2;
  localparam logic [3:0] ALU_OR  = 4'd3;
  localparam logic [3:0] ALU_SHR = 4'd4;
  localparam logic [3:0] ALU_SHL = 4'd5;
  localparam logic [3:0] ALU_ROR = 4'd6;
  localparam logic [3:0] ALU_ROL = 4'd7;
  localparam logic [3:0] ALU_MUL = 4'd8;
  localparam logic [3:0] ALU_DIV = 4'd9;
  localparam logic [3:0] ALU_NEG = 4'd10;
  localparam logic [3:0] ALU_NOT = 4'd11;

  // Execution flavour of an instruction; decides the T3..T7 micro-steps.
  typedef enum logic [2:0] {
    CLS_ILLEGAL = 3'd0,
    CLS_RTYPE   = 3'd1,
    CLS_MULDIV  = 3'd2,
    CLS_UNARY   = 3'd3,
    CLS_LOAD    = 3'd4,
    CLS_STORE   = 3'd5,
    CLS_NOP     = 3'd6,
    CLS_HALT    = 3'd7
  } op_class_t;

  function automatic op_class_t classify(input logic [4:0] opcode);
    op_class_t cls;
    case (opcode)
      OP_ADD, OP_SUB, OP_AND, OP_OR,
      OP_SHR, OP_SHL, OP_ROR, OP_ROL: cls = CLS_RTYPE;
      OP_MUL, OP_DIV:                 cls = CLS_MULDIV;
      OP_NEG, OP_NOT:                 cls = CLS_UNARY;
      OP_LD:                          cls = CLS_LOAD;
      OP_ST:                          cls = CLS_STORE;
      OP_NOP:                         cls = CLS_NOP;
      OP_HALT:                        cls = CLS_HALT;
      default:                        cls = CLS_ILLEGAL;
    endcase
    return cls;
  endfunction

  function automatic logic [3:0] alu_code(input logic [4:0] opcode);
    logic [3:0] code;
    case (opcode)
      OP_ADD:  code = ALU_ADD;
      OP_SUB:  code = ALU_SUB;
      OP_AND:  code = ALU_AND;
      OP_OR:   code = ALU_OR;
      OP_SHR:  code = ALU_SHR;
      OP_SHL:  code = ALU_SHL;
      OP_ROR:  code = ALU_ROR;
      OP_ROL:  code = ALU_ROL;
      OP_MUL:  code = ALU_MUL;
      OP_DIV:  code = ALU_DIV;
      OP_NEG:  code = ALU_NEG;
      OP_NOT:  code = ALU_NOT;
      default: code = ALU_ADD;
    endcase
    return code;
  endfunction

endpackage

// File: rtl/reg_select.sv
// Decodes a 4-bit register field into a one-hot GPR select, all-zero when
// the enable is low.
module reg_select (
  input  logic [3:0]  field,
  input  logic        enable,
  output logic [15:0] onehot
);

  // One-hot decode gated by enable.
  always_comb begin
    onehot = 16'h0000;
    if (enable) begin
      onehot[field] = 1'b1;
    end else begin
      onehot = 16'h0000;
    end
  end

endmodule

// File: rtl/control_unit.sv
// Moore-style control unit for a multi-cycle datapath. The state register
// plus the IR value fully determine every output; memory waits are bounded
// by MEM_WAIT_MAX (0 = unbounded).
module control_unit
  import cpu_pkg::*;
#(
  parameter int unsigned MEM_WAIT_MAX = 32'd0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] IR,
  input  logic        mem_ready,
  input  logic        stop,
  output logic        PCout,
  output logic        Zhighout,
  output logic        Zlowout,
  output logic        MDRout,
  output logic        HIout,
  output logic        LOout,
  output logic        Cout,
  output logic        PCin,
  output logic        IRin,
  output logic        MARin,
  output logic        MDRin,
  output logic        Yin,
  output logic        Zin,
  output logic        HIin,
  output logic        LOin,
  output logic        IncPC,
  output logic [15:0] Rin,
  output logic [15:0] Rout,
  output logic        Read,
  output logic        Write,
  output logic [3:0]  control,
  output logic [31:0] C_sext,
  output logic        run,
  output logic        illegal,
  output logic        mem_err
);

  localparam bit          WAIT_BOUNDED = (MEM_WAIT_MAX != 32'd0);
  localparam logic [31:0] WAIT_LAST    = (MEM_WAIT_MAX == 32'd0) ? 32'd0 : (MEM_WAIT_MAX - 32'd1);

  state_t      state_r;
  logic [31:0] wait_cnt_r;
  logic        mem_err_r;

  logic [4:0]  opcode_s;
  logic [3:0]  ra_s;
  logic [3:0]  rb_s;
  logic [3:0]  rc_s;
  op_class_t   cls_s;
  logic        exec_s;
  logic        in_wait_s;

  logic        rin_en_s;
  logic [3:0]  rin_field_s;
  logic        rout_en_s;
  logic [3:0]  rout_field_s;

  assign opcode_s = IR[31:27];
  assign ra_s     = IR[26:23];
  assign rb_s     = IR[22:19];
  assign rc_s     = IR[18:15];
  assign cls_s    = classify(opcode_s);

  // Classes that run beyond fetch and need the T3+ micro-steps.
  always_comb begin
    case (cls_s)
      CLS_RTYPE, CLS_MULDIV, CLS_UNARY, CLS_LOAD, CLS_STORE: exec_s = 1'b1;
      default:                                               exec_s = 1'b0;
    endcase
  end

  // States that stall on mem_ready: fetch read, load read, store write.
  always_comb begin
    case (state_r)
      S_T1:    in_wait_s = 1'b1;
      S_T6:    in_wait_s = (cls_s == CLS_LOAD);
      S_T7:    in_wait_s = (cls_s == CLS_STORE);
      default: in_wait_s = 1'b0;
    endcase
  end

  // Sequencer: state, memory-wait counter and the registered mem_err pulse.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_r    <= S_RST;
      wait_cnt_r <= 32'd0;
      mem_err_r  <= 1'b0;
    end else begin
      mem_err_r  <= 1'b0;
      wait_cnt_r <= 32'd0;
      if (in_wait_s && !mem_ready) begin
        if (WAIT_BOUNDED && (wait_cnt_r == WAIT_LAST)) begin
          state_r   <= S_HALT;
          mem_err_r <= 1'b1;
        end else begin
          wait_cnt_r <= wait_cnt_r + 32'd1;
        end
      end else begin
        case (state_r)
          S_RST: state_r <= S_T0;
          S_T0: begin
            if (stop) begin
              state_r <= S_HALT;
            end else begin
              state_r <= S_T1;
            end
          end
          S_T1: state_r <= S_T2;
          S_T2: begin
            case (cls_s)
              CLS_HALT:             state_r <= S_HALT;
              CLS_NOP, CLS_ILLEGAL: state_r <= S_T0;
              default:              state_r <= S_T3;
            endcase
          end
          S_T3: begin
            if (exec_s) begin
              state_r <= S_T4;
            end else begin
              state_r <= S_T0;
            end
          end
          S_T4: begin
            if (exec_s && (cls_s != CLS_UNARY)) begin
              state_r <= S_T5;
            end else begin
              state_r <= S_T0;
            end
          end
          S_T5: begin
            case (cls_s)
              CLS_MULDIV, CLS_LOAD, CLS_STORE: state_r <= S_T6;
              default:                         state_r <= S_T0;
            endcase
          end
          S_T6: begin
            case (cls_s)
              CLS_LOAD, CLS_STORE: state_r <= S_T7;
              default:             state_r <= S_T0;
            endcase
          end
          S_T7:   state_r <= S_T0;
          S_HALT: state_r <= S_HALT;
          default: state_r <= S_RST;
        endcase
      end
    end
  end

  // Micro-step decode: control strobes and GPR field selects per state.
  always_comb begin
    PCout = 1'b0; Zhighout = 1'b0; Zlowout = 1'b0; MDRout = 1'b0;
    HIout = 1'b0; LOout = 1'b0; Cout = 1'b0;
    PCin = 1'b0; IRin = 1'b0; MARin = 1'b0; MDRin = 1'b0; Yin = 1'b0;
    Zin = 1'b0; HIin = 1'b0; LOin = 1'b0; IncPC = 1'b0;
    Read = 1'b0; Write = 1'b0;
    control = ALU_ADD;
    rin_en_s = 1'b0;  rin_field_s = 4'd0;
    rout_en_s = 1'b0; rout_field_s = 4'd0;
    case (state_r)
      S_T0: begin
        PCout = 1'b1; MARin = 1'b1; IncPC = 1'b1; Zin = 1'b1;
      end
      S_T1: begin
        Zlowout = 1'b1; PCin = 1'b1; Read = 1'b1; MDRin = 1'b1;
      end
      S_T2: begin
        MDRout = 1'b1; IRin = 1'b1;
      end
      S_T3: begin
        case (cls_s)
          CLS_RTYPE, CLS_LOAD, CLS_STORE: begin
            rout_en_s = 1'b1; rout_field_s = rb_s; Yin = 1'b1;
          end
          CLS_MULDIV: begin
            rout_en_s = 1'b1; rout_field_s = ra_s; Yin = 1'b1;
          end
          CLS_UNARY: begin
            rout_en_s = 1'b1; rout_field_s = rb_s;
            control = alu_code(opcode_s); Zin = 1'b1;
          end
          default: ;
        endcase
      end
      S_T4: begin
        case (cls_s)
          CLS_RTYPE: begin
            rout_en_s = 1'b1; rout_field_s = rc_s;
            control = alu_code(opcode_s); Zin = 1'b1;
          end
          CLS_MULDIV: begin
            rout_en_s = 1'b1; rout_field_s = rb_s;
            control = alu_code(opcode_s); Zin = 1'b1;
          end
          CLS_UNARY: begin
            Zlowout = 1'b1; rin_en_s = 1'b1; rin_field_s = ra_s;
          end
          CLS_LOAD, CLS_STORE: begin
            Cout = 1'b1; control = ALU_ADD; Zin = 1'b1;
          end
          default: ;
        endcase
      end
      S_T5: begin
        case (cls_s)
          CLS_RTYPE: begin
            Zlowout = 1'b1; rin_en_s = 1'b1; rin_field_s = ra_s;
          end
          CLS_MULDIV: begin
            Zlowout = 1'b1; LOin = 1'b1;
          end
          CLS_LOAD, CLS_STORE: begin
            Zlowout = 1'b1; MARin = 1'b1;
          end
          default: ;
        endcase
      end
      S_T6: begin
        case (cls_s)
          CLS_MULDIV: begin
            Zhighout = 1'b1; HIin = 1'b1;
          end
          CLS_LOAD: begin
            Read = 1'b1; MDRin = 1'b1;
          end
          CLS_STORE: begin
            rout_en_s = 1'b1; rout_field_s = ra_s; MDRin = 1'b1;
          end
          default: ;
        endcase
      end
      S_T7: begin
        case (cls_s)
          CLS_LOAD: begin
            MDRout = 1'b1; rin_en_s = 1'b1; rin_field_s = ra_s;
          end
          CLS_STORE: Write = 1'b1;
          default: ;
        endcase
      end
      default: ;
    endcase
  end

  // Status outputs: run, illegal-opcode pulse and the immediate constant.
  always_comb begin
    run     = (state_r != S_RST) && (state_r != S_HALT);
    illegal = (state_r == S_T2) && (cls_s == CLS_ILLEGAL);
    mem_err = mem_err_r;
    if (state_r == S_RST) begin
      C_sext = 32'd0;
    end else begin
      C_sext = {{13{IR[18]}}, IR[18:0]};
    end
  end

  reg_select u_rin_sel (
    .field  (rin_field_s),
    .enable (rin_en_s),
    .onehot (Rin)
  );

  reg_select u_rout_sel (
    .field  (rout_field_s),
    .enable (rout_en_s),
    .onehot (Rout)
  );

endmodule
